// File: rtl/prominence_pkg.sv
// prominence_pkg: state encoding, frame length default and counter helpers shared by the frame scheduler.
package prominence_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SYNC     = 3'd1;
    localparam logic [2:0] ST_ARM      = 3'd2;
    localparam logic [2:0] ST_PASS     = 3'd3;
    localparam logic [2:0] ST_FLUSH    = 3'd4;
    localparam logic [2:0] ST_WAITDONE = 3'd5;
    localparam logic [2:0] ST_SKIP     = 3'd6;

    localparam int FRAME_LEN_DEF = 1024;
    localparam int CNT_W         = 16;

    // Saturating increment used by the status counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/prom_sched_watchdog.sv
// prom_sched_watchdog: loadable down-counter that pulses expire on its last enabled count.
module prom_sched_watchdog #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ce,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    assign expire = en && (cnt == W'(1));

    // Clear wins over load; a zero load value parks the counter so it never expires.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            cnt <= '0;
        else if (ce)
            cnt <= clr ? '0 : load ? load_val : (en && cnt != '0) ? cnt - 1'b1 : cnt;

endmodule

// File: rtl/prominence_frame_sched.sv
// prominence_frame_sched: gates the spectrum stream to whole aligned frames, starts the engine, waits for done, decimates.
// Optional completion watchdog in WAITDONE is built only when PROM_SCHED_TIMEOUT_EN is defined.
module prominence_frame_sched
    import prominence_pkg::*;
#(
    parameter int DW        = 16,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int TO_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic [DW-1:0]    s_tdata,
    input  logic             s_tuser,
    input  logic             s_tlast,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [DW-1:0]    m_tdata,
    output logic             m_tuser,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic             cfg_cont,
    input  logic [3:0]       cfg_decim,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             irq_en,
    input  logic             irq_clr,
    output logic             eng_start,
    input  logic             eng_done,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             err_short,
    output logic             err_long,
    output logic             err_timeout,
    output logic             irq
);

    localparam logic [9:0] LAST_IDX = 10'(FRAME_LEN - 1);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [9:0] beat_cnt;
    logic       cont_q;
    logic [3:0] decim_q;
    logic [3:0] skip_cnt;
    logic       abort_pend;
    logic       irq_pend;
    logic       in_pass;
    logic       at_end;
    logic       acc;
    logic       acc_last;
    logic       start_ok;
    logic       abort;
    logic       done_ok;
    logic       frame_end;
    logic       tmo;

    assign in_pass   = state == ST_PASS;
    assign at_end    = beat_cnt == LAST_IDX;
    assign acc       = s_tvalid && s_tready;
    assign acc_last  = acc && s_tlast;
    assign start_ok  = ce && cmd_start && !cmd_abort && state == ST_IDLE;
    assign abort     = ce && cmd_abort;
    assign done_ok   = ce && eng_done && state == ST_WAITDONE;
    assign frame_end = in_pass && acc && (s_tlast || at_end);

    // Upstream ready: hold the frame-start beat in SYNC, follow the engine in PASS, drain while discarding.
    assign s_tready = !ce ? 1'b0 :
                      (state == ST_SYNC) ? !(s_tvalid && s_tuser) :
                      in_pass ? m_tready :
                      (state == ST_FLUSH || state == ST_WAITDONE || state == ST_SKIP);

    // Passthrough to the engine; the last bin of a frame is always marked even if upstream runs long.
    assign m_tdata  = s_tdata;
    assign m_tuser  = in_pass && s_tuser;
    assign m_tlast  = in_pass && (s_tlast || at_end);
    assign m_tvalid = ce && in_pass && s_tvalid;

    assign eng_start = ce && state == ST_ARM;
    assign busy      = state != ST_IDLE;
    assign irq       = irq_pend && irq_en;

    // Next-state selection; abort wins everywhere except PASS, where the frame finishes downstream first.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     state_nx = start_ok ? ST_SYNC : ST_IDLE;
            ST_SYNC:     state_nx = abort ? ST_IDLE : (ce && s_tvalid && s_tuser) ? ST_ARM : ST_SYNC;
            ST_ARM:      state_nx = abort ? ST_IDLE : ce ? ST_PASS : ST_ARM;
            ST_PASS:     state_nx = !frame_end ? ST_PASS :
                                    (abort_pend || abort) ? ST_IDLE :
                                    s_tlast ? ST_WAITDONE : ST_FLUSH;
            ST_FLUSH:    state_nx = abort ? ST_IDLE : acc_last ? ST_WAITDONE : ST_FLUSH;
            ST_WAITDONE: state_nx = abort ? ST_IDLE :
                                    done_ok ? (!cont_q ? ST_IDLE : (decim_q == 4'd0) ? ST_SYNC : ST_SKIP) :
                                    tmo ? ST_IDLE : ST_WAITDONE;
            ST_SKIP:     state_nx = abort ? ST_IDLE : (acc_last && skip_cnt == 4'd1) ? ST_SYNC : ST_SKIP;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // Sequential state, configuration latch, counters, sticky errors and interrupt pending.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            cont_q     <= 1'b0;
            decim_q    <= '0;
            skip_cnt   <= '0;
            abort_pend <= 1'b0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            irq_pend   <= 1'b0;
        end else if (ce) begin
            state      <= state_nx;
            cont_q     <= start_ok ? cfg_cont : cont_q;
            decim_q    <= start_ok ? cfg_decim : decim_q;
            beat_cnt   <= !in_pass ? '0 : acc ? beat_cnt + 10'd1 : beat_cnt;
            abort_pend <= in_pass && (abort_pend || abort);
            skip_cnt   <= done_ok ? decim_q : (state == ST_SKIP && acc_last) ? skip_cnt - 4'd1 : skip_cnt;
            frame_cnt  <= start_ok ? '0 : done_ok ? sat_inc(frame_cnt) : frame_cnt;
            drop_cnt   <= (acc_last && (state == ST_WAITDONE || state == ST_SKIP)) ? sat_inc(drop_cnt) : drop_cnt;
            err_short  <= !start_ok && (err_short || (in_pass && acc && s_tlast && !at_end));
            err_long   <= !start_ok && (err_long || (in_pass && acc && at_end && !s_tlast));
            irq_pend   <= done_ok || tmo || (irq_pend && !irq_clr);
        end

`ifdef PROM_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] timeout_q;

    prom_sched_watchdog #(.W(TO_W)) u_wd (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .clr      (state == ST_IDLE),
        .load     (state != ST_WAITDONE),
        .en       (ce && state == ST_WAITDONE),
        .load_val (timeout_q),
        .expire   (tmo)
    );

    // Timeout value is latched with the run; the flag is sticky until the next start.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            timeout_q   <= '0;
            err_timeout <= 1'b0;
        end else if (ce) begin
            timeout_q   <= start_ok ? cfg_timeout : timeout_q;
            err_timeout <= !start_ok && (err_timeout || (tmo && !done_ok));
        end
`else
    logic unused_cfg;

    assign unused_cfg  = &{1'b0, cfg_timeout};
    assign tmo         = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
